regfile_writeback_arbiter: RTL and testbench



---
 rtl/regfile_writeback_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_writeback_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter: merges ALU (via FIFO) and memory results onto the register file write port
module regfile_writeback_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_pos,
    input  logic [DATA_W-1:0] alu_value,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_pos,
    input  logic [DATA_W-1:0] mem_value,
    output logic              we,
    output logic [ADDR_W-1:0] pos,
    output logic [DATA_W-1:0] writevalue,
    input  logic [ADDR_W-1:0] query_pos,
    output logic              query_pending
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] full_count = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] starve_max = SW'(STARVE_MAX);

    logic [ADDR_W-1:0]     fifo_pos [FIFO_DEPTH];
    logic [DATA_W-1:0]     fifo_val [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_vld;
    logic [PW-1:0]         rd, wr;
    logic [CW-1:0]         count;
    logic [SW-1:0]         starve_cnt;
    logic                  nonempty, waw_hit, query_hit, mem_issue, pop, push, issue;
    logic [ADDR_W-1:0]     issue_pos;
    logic [DATA_W-1:0]     issue_val;

    assign nonempty  = count != '0;
    assign alu_ready = reset_n & (count < full_count);
    assign mem_ready = reset_n & !((starve_cnt == starve_max) & nonempty) & !waw_hit;
    assign mem_issue = mem_valid & mem_ready;
    assign pop       = !mem_issue & nonempty;
    assign push      = alu_valid & alu_ready & (alu_pos != '0);
    assign issue     = mem_issue | pop;
    assign issue_pos = mem_issue ? mem_pos : fifo_pos[rd];
    assign issue_val = mem_issue ? mem_value : fifo_val[rd];
    assign query_pending = (query_pos != '0) & (query_hit | (we & (pos == query_pos)));

    // Match memory and hazard-probe indices against every occupied FIFO slot
    always_comb begin
        waw_hit   = 1'b0;
        query_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            waw_hit   = waw_hit | (fifo_vld[i] & (fifo_pos[i] == mem_pos));
            query_hit = query_hit | (fifo_vld[i] & (fifo_pos[i] == query_pos));
        end
    end

    // FIFO payload storage needs no reset; occupancy is tracked by fifo_vld
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_pos[wr] <= alu_pos;
            fifo_val[wr] <= alu_value;
        end
    end

    // FIFO pointers, occupancy and starvation counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd         <= '0;
            wr         <= '0;
            count      <= '0;
            fifo_vld   <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) begin
                fifo_vld[wr] <= 1'b1;
                wr           <= wr + 1'b1;
            end
            if (pop) begin
                fifo_vld[rd] <= 1'b0;
                rd           <= rd + 1'b1;
            end
            count      <= count + CW'(push) - CW'(pop);
            starve_cnt <= (mem_issue & nonempty) ? ((starve_cnt == starve_max) ? starve_max : starve_cnt + 1'b1) : '0;
        end
    end

    // Registered write port; register 0 writes are swallowed, idle cycles hold pos/data
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            we         <= 1'b0;
            pos        <= '0;
            writevalue <= '0;
        end else begin
            we <= issue & (issue_pos != '0);
            if (issue & (issue_pos != '0)) begin
                pos        <= issue_pos;
                writevalue <= issue_val;
            end
        end
    end
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb_regfile_writeback_arbiter: directed vectors for the writeback arbiter
module tb_regfile_writeback_arbiter;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        alu_valid = 1'b0, alu_ready;
    logic [4:0]  alu_pos = '0;
    logic [31:0] alu_value = '0;
    logic        mem_valid = 1'b0, mem_ready;
    logic [4:0]  mem_pos = '0;
    logic [31:0] mem_value = '0;
    logic        we;
    logic [4:0]  pos;
    logic [31:0] writevalue;
    logic [4:0]  query_pos = '0;
    logic        query_pending;
    int          errors = 0;
    int          checks = 0;

    regfile_writeback_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_pos(alu_pos), .alu_value(alu_value),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_pos(mem_pos), .mem_value(mem_value),
        .we(we), .pos(pos), .writevalue(writevalue),
        .query_pos(query_pos), .query_pending(query_pending)
    );

    // Free-running clock
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic port(input string tag, input logic w, input logic [4:0] p, input logic [31:0] v);
        check({tag, ".we"}, 32'(we), 32'(w));
        check({tag, ".pos"}, 32'(pos), 32'(p));
        check({tag, ".val"}, writevalue, v);
    endtask

    initial begin
        #2;
        port("rst", 1'b0, 5'd0, 32'h0);
        check("rst.alu_ready", 32'(alu_ready), 0);
        check("rst.mem_ready", 32'(mem_ready), 0);
        check("rst.qp", 32'(query_pending), 0);
        tick;
        tick;
        reset_n = 1'b1;
        // 1: memory write, one-cycle latency
        mem_valid = 1'b1; mem_pos = 5'd7; mem_value = 32'hDEADBEEF;
        #1;
        check("t1.mem_ready", 32'(mem_ready), 1);
        check("t1.alu_ready", 32'(alu_ready), 1);
        tick;
        mem_valid = 1'b0;
        port("t1.issue", 1'b1, 5'd7, 32'hDEADBEEF);
        tick;
        port("t1.idle", 1'b0, 5'd7, 32'hDEADBEEF);
        // 2: two ALU writes back to back
        alu_valid = 1'b1; alu_pos = 5'd3; alu_value = 32'h11; query_pos = 5'd4;
        #1;
        check("t2.ready0", 32'(alu_ready), 1);
        check("t2.qp0", 32'(query_pending), 0);
        tick;
        alu_pos = 5'd4; alu_value = 32'h22;
        #1;
        check("t2.we_early", 32'(we), 0);
        check("t2.ready1", 32'(alu_ready), 1);
        check("t2.qp1", 32'(query_pending), 0);
        tick;
        alu_valid = 1'b0;
        port("t2.r3", 1'b1, 5'd3, 32'h11);
        check("t2.qp_fifo", 32'(query_pending), 1);
        tick;
        port("t2.r4", 1'b1, 5'd4, 32'h22);
        check("t2.qp_we", 32'(query_pending), 1);
        tick;
        check("t2.we_off", 32'(we), 0);
        check("t2.qp_off", 32'(query_pending), 0);
        // 3: fill FIFO while memory holds the port
        alu_valid = 1'b1; alu_pos = 5'd10; alu_value = 32'h100;
        mem_valid = 1'b1; mem_pos = 5'd20; mem_value = 32'h200;
        tick;
        port("t3.m20", 1'b1, 5'd20, 32'h200);
        alu_pos = 5'd11; alu_value = 32'h101; mem_pos = 5'd21; mem_value = 32'h201;
        #1;
        check("t3.ready_one", 32'(alu_ready), 1);
        tick;
        port("t3.m21", 1'b1, 5'd21, 32'h201);
        mem_valid = 1'b0; alu_pos = 5'd12; alu_value = 32'h102;
        #1;
        check("t3.ready_full", 32'(alu_ready), 0);
        tick;
        port("t3.r10", 1'b1, 5'd10, 32'h100);
        check("t3.ready_pop", 32'(alu_ready), 1);
        tick;
        alu_valid = 1'b0;
        port("t3.r11", 1'b1, 5'd11, 32'h101);
        tick;
        port("t3.r12", 1'b1, 5'd12, 32'h102);
        tick;
        check("t3.drained", 32'(we), 0);
        // 4: starvation bound
        alu_valid = 1'b1; alu_pos = 5'd5; alu_value = 32'h55;
        tick;
        alu_valid = 1'b0; mem_valid = 1'b1; mem_pos = 5'd9;
        for (int k = 0; k < 3; k++) begin
            mem_value = 32'h90 + 32'(k);
            #1;
            check("t4.mem_ready", 32'(mem_ready), 1);
            tick;
            port("t4.m9", 1'b1, 5'd9, 32'h90 + 32'(k));
        end
        #1;
        check("t4.blocked", 32'(mem_ready), 0);
        tick;
        port("t4.r5", 1'b1, 5'd5, 32'h55);
        mem_value = 32'h99;
        #1;
        check("t4.resume", 32'(mem_ready), 1);
        tick;
        mem_valid = 1'b0;
        port("t4.m9b", 1'b1, 5'd9, 32'h99);
        tick;
        // 5: WAW hold-off
        alu_valid = 1'b1; alu_pos = 5'd6; alu_value = 32'hA;
        tick;
        alu_valid = 1'b0; mem_valid = 1'b1; mem_pos = 5'd6; mem_value = 32'hB; query_pos = 5'd6;
        #1;
        check("t5.waw", 32'(mem_ready), 0);
        check("t5.qp", 32'(query_pending), 1);
        tick;
        port("t5.first", 1'b1, 5'd6, 32'hA);
        check("t5.release", 32'(mem_ready), 1);
        tick;
        mem_valid = 1'b0;
        port("t5.second", 1'b1, 5'd6, 32'hB);
        tick;
        check("t5.idle", 32'(we), 0);
        // 6: async reset mid-stream
        alu_valid = 1'b1; alu_pos = 5'd10; alu_value = 32'h1;
        mem_valid = 1'b1; mem_pos = 5'd20; mem_value = 32'h2;
        tick;
        alu_pos = 5'd11; mem_pos = 5'd21;
        tick;
        alu_valid = 1'b0; mem_valid = 1'b0; query_pos = 5'd10;
        #1;
        check("t6.pre_we", 32'(we), 1);
        check("t6.pre_qp", 32'(query_pending), 1);
        #1;
        reset_n = 1'b0;
        #1;
        port("t6.async", 1'b0, 5'd0, 32'h0);
        check("t6.alu_ready", 32'(alu_ready), 0);
        check("t6.qp", 32'(query_pending), 0);
        tick;
        reset_n = 1'b1;
        #1;
        check("t6.ready_after", 32'(alu_ready), 1);
        tick;
        port("t6.no_stale0", 1'b0, 5'd0, 32'h0);
        tick;
        port("t6.no_stale1", 1'b0, 5'd0, 32'h0);
        check("t6.qp_after", 32'(query_pending), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
